// File: rtl/des_core.sv
// rtl/des_core.sv - iterative single-DES engine, one Feistel round per clock
//
// Purpose : encrypts or decrypts one 64-bit block with a 56-bit PC-1 permuted
//           key in 16 clocks, reusing one round datapath every cycle.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           s    - start, accepted only while idle
//           e    - direction captured with start (1 = encrypt, 0 = decrypt)
//           k    - key {C0, D0}, parity-stripped and PC-1 permuted
//           in   - input block captured with start
//           out  - registered result block
//           busy - high while rounds are in progress
//           done - one-cycle pulse when out is updated

module des_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        s,
    input  logic        e,
    input  logic [55:0] k,
    input  logic [63:0] in,
    output logic [63:0] out,
    output logic        busy,
    output logic        done
);

    // Table entries use FIPS numbering: bit 1 is the MSB of each vector.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // S-box contents row-major: entry index = {row[1:0], col[3:0]}.
    localparam int SBOX_T [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] f_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] f_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [27:0] f_rot(input logic [27:0] x, input logic [1:0] amt,
                                          input logic left);
        case (amt)
            2'd1:    return left ? {x[26:0], x[27]}    : {x[0],    x[27:1]};
            2'd2:    return left ? {x[25:0], x[27:26]} : {x[1:0],  x[27:2]};
            default: return x;
        endcase
    endfunction

    logic [31:0]       r_l;
    logic [31:0]       r_r;
    logic [27:0]       r_c;
    logic [27:0]       r_d;
    logic [3:0]        r_cnt;
    logic              r_dir;
    logic              r_busy;
    logic              r_done;
    logic [63:0]       r_out;

    logic [1:0]        w_amt;
    logic [27:0]       w_c_rot;
    logic [27:0]       w_d_rot;
    logic [47:0]       w_ki;
    logic [7:0][5:0]   w_six;
    logic [7:0][3:0]   w_sbo;
    logic [31:0]       w_f;
    logic [31:0]       w_r_next;
    logic [63:0]       w_ip;
    logic [63:0]       w_fp;

    // Decrypt walks the schedule backwards: the loaded {C0,D0} already equals
    // {C16,D16}, so round 1 needs no rotation and later rounds undo the
    // encrypt shift of the round they mirror.
    always_comb begin
        w_amt = 2'd2;
        if (r_cnt == 4'd0) begin
            w_amt = r_dir ? 2'd1 : 2'd0;
        end else if (r_cnt == 4'd1 || r_cnt == 4'd8 || r_cnt == 4'd15) begin
            w_amt = 2'd1;
        end
    end

    assign w_c_rot = f_rot(r_c, w_amt, r_dir);
    assign w_d_rot = f_rot(r_d, w_amt, r_dir);
    assign w_ki    = f_pc2({w_c_rot, w_d_rot});
    assign w_six   = f_e(r_r) ^ w_ki;

    // w_six[7] feeds S1; row is the outer bit pair, column the middle four.
    always_comb begin
        w_sbo = '0;
        for (int b = 0; b < 8; b++) begin
            w_sbo[3'(7 - b)] = 4'(SBOX_T[b][{w_six[3'(7 - b)][5], w_six[3'(7 - b)][0],
                                            w_six[3'(7 - b)][4:1]}]);
        end
    end

    assign w_f      = f_p(w_sbo);
    assign w_r_next = r_l ^ w_f;
    assign w_ip     = f_ip(in);
    // Round-16 output halves are swapped before the inverse permutation.
    assign w_fp     = f_fp({w_r_next, r_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_l    <= '0;
            r_r    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_out  <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (s) begin
                    r_l    <= w_ip[63:32];
                    r_r    <= w_ip[31:0];
                    r_c    <= k[55:28];
                    r_d    <= k[27:0];
                    r_dir  <= e;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                end
            end else begin
                r_c   <= w_c_rot;
                r_d   <= w_d_rot;
                r_l   <= r_r;
                r_r   <= w_r_next;
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_out  <= w_fp;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_des_core.sv
// tb/tb_des_core.sv - scoreboard bench for des_core against a behavioural DES model

module tb_des_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s   = 1'b0;
    logic        e   = 1'b0;
    logic [55:0] k   = '0;
    logic [63:0] in_blk = '0;
    logic [63:0] out;
    logic        busy;
    logic        done;

    des_core dut (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .e    (e),
        .k    (k),
        .in   (in_blk),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- behavioural reference model ----------------
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int T_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int T_FP [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int T_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int T_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SB [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

    // sel: 0=IP 1=FP 2=E 3=P 4=PC-2; i is the 1-based output position.
    function automatic int tab(input int sel, input int i);
        case (sel)
            0:       return T_IP[i - 1];
            1:       return T_FP[i - 1];
            2:       return T_E[i - 1];
            3:       return T_P[i - 1];
            default: return T_PC2[i - 1];
        endcase
    endfunction

    // Output bit i (standard numbering, 1 = MSB) takes input bit tab(sel,i).
    function automatic logic [63:0] permute(input logic [63:0] x, input int nin,
                                            input int nout, input int sel);
        logic [63:0] y = '0;
        for (int i = 1; i <= nout; i++) y[6'(nout - i)] = x[6'(nin - tab(sel, i))];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] kk);
        logic [47:0] x;
        logic [31:0] so = '0;
        logic [5:0]  six;
        x = 48'(permute({32'd0, r}, 32, 48, 2)) ^ kk;
        for (int b = 0; b < 8; b++) begin
            six = 6'(x >> (42 - 6 * b));
            so  = {so[27:0], 4'(SB[b][{six[5], six[0]}][six[4:1]])};
        end
        return 32'(permute({32'd0, so}, 32, 32, 3));
    endfunction

    function automatic logic [63:0] des_ref(input logic [55:0] key, input logic [63:0] blk,
                                            input logic enc);
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [31:0] l, r, t;
        logic [63:0] x;
        c = key[55:28];
        d = key[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int n = 0; n < SHIFTS[i]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = 48'(permute({8'd0, c, d}, 56, 48, 4));
        end
        x = permute(blk, 64, 64, 0);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ feistel(r, enc ? ks[i] : ks[15 - i]);
            l = t;
        end
        return permute({r, l}, 64, 64, 1);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    logic [63:0] last_out = '0;

    // Monitor: every done pulse must match the oldest pending expectation in
    // value and cycle; out may only change on done or on reset.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: done pulse at cycle %0d with no block pending", cyc);
            end else begin
                exp_t ex;
                ex = exp_q.pop_front();
                check("result", out, ex.val);
                check("done_cycle", 64'(cyc), 64'(ex.cyc));
            end
        end else if (rst_q === 1'b0 && out !== last_out) begin
            n_vec++;
            n_bad++;
            $display("FAIL out_stable: out changed %h -> %h without done", last_out, out);
        end
        last_out = out;
    end

    // ---------------- stimulus ----------------
    // Called at a negedge while idle; the start is sampled at the next edge,
    // so done is due 17 counted edges after the current cycle count.
    task automatic start_blk(input logic [55:0] key, input logic [63:0] data,
                             input logic enc, input bit expect_done);
        exp_t ex;
        k      = key;
        in_blk = data;
        e      = enc;
        s      = 1'b1;
        if (expect_done) begin
            ex.val = des_ref(key, data, enc);
            ex.cyc = cyc + 17;
            exp_q.push_back(ex);
        end
        @(negedge clk);
        s = 1'b0;
    endtask

    // Runs the 16 busy cycles, optionally hammering s with junk, and leaves
    // the bench at the negedge where done should be high.
    task automatic run_wait(input bit hammer);
        int bad_busy = 0;
        for (int j = 0; j < 16; j++) begin
            if (busy !== 1'b1) bad_busy++;
            if (hammer) begin
                s      = 1'b1;
                e      = 1'($urandom);
                in_blk = {$urandom, $urandom};
                k      = 56'({$urandom, $urandom});
            end
            @(negedge clk);
        end
        s = 1'b0;
        check("busy_16_cycles", 64'(bad_busy), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_cleared", 64'(busy), 64'd0);
    endtask

    localparam logic [55:0] KAT_K  = 56'hF0CCAAF556678F;
    localparam logic [63:0] KAT_PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT = 64'h85E813540F0AB405;
    localparam logic [63:0] ZERO_CT = 64'h8CA64DE9C1B123A7;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] rk;
        logic [63:0] rd;
        logic        re;
        bit          hm;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out", out, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        start_blk(KAT_K, KAT_PT, 1'b1, 1'b1);
        run_wait(1'b0);
        check("kat_encrypt", out, KAT_CT);

        start_blk(KAT_K, KAT_CT, 1'b0, 1'b1);
        run_wait(1'b0);
        check("kat_decrypt", out, KAT_PT);

        start_blk(56'd0, 64'd0, 1'b1, 1'b1);
        run_wait(1'b0);
        check("zero_encrypt", out, ZERO_CT);

        start_blk(56'd0, ZERO_CT, 1'b0, 1'b1);
        run_wait(1'b0);
        check("zero_decrypt", out, 64'd0);

        start_blk(KAT_K, KAT_PT, 1'b1, 1'b1);
        run_wait(1'b1);
        check("busy_protect", out, KAT_CT);

        // Reset lands on the edge that would perform round 8.
        start_blk(KAT_K, KAT_PT, 1'b1, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_out", out, 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        repeat (20) @(negedge clk);

        start_blk(KAT_K, KAT_PT, 1'b1, 1'b1);
        run_wait(1'b0);
        check("after_reset", out, KAT_CT);

        // Back-to-back: the decrypt start is presented at the done cycle.
        start_blk(KAT_K, KAT_PT, 1'b1, 1'b1);
        run_wait(1'b0);
        check("b2b_encrypt", out, KAT_CT);
        start_blk(KAT_K, KAT_CT, 1'b0, 1'b1);
        run_wait(1'b0);
        check("b2b_decrypt", out, KAT_PT);

        for (int n = 0; n < 12; n++) begin
            rk = 56'({$urandom, $urandom});
            rd = {$urandom, $urandom};
            re = 1'($urandom);
            hm = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_blk(rk, rd, re, 1'b1);
            run_wait(hm);
            start_blk(rk, out, ~re, 1'b1);
            run_wait(1'b0);
            check("round_trip", out, rd);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
